// File: rtl/s2mm_sts_tracker.sv
// Purpose : gate S2MM DataMover commands on an outstanding limit and match statuses to completion/error flags.
// Latency : command path is combinational (0 cycles); status effects are visible 1 cycle after the sts handshake.
// Backpres: cmd tready/tvalid drop while in ERR or at MAX_OUTSTANDING; status is always accepted outside reset.
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   s_axis_cmd_*  : command in from s2mm_cmd_gen     m_axis_cmd_* : command out to DataMover
//   s_axis_sts_*  : DataMover status (tag[3:0], INTERR[4], DECERR[5], SLVERR[6], OKAY[7])
//   clear         : zeroes err_code, model_done, tile_cnt and leaves ERR
//   tile_done, model_done, err, err_code{PROTO,SLVERR,DECERR,INTERR}, outstanding, tile_cnt
// Optional feature: define S2MM_STS_TAG_CHECK_EN to match every status tag against the issued command tag.
module s2mm_sts_tracker #(
  parameter int CORE_CMD_WIDTH  = 80,
  parameter int MAX_OUTSTANDING = 16,
  parameter int OUTSTD_W        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CORE_CMD_WIDTH-1:0] s_axis_cmd_tdata,
  input  logic                      s_axis_cmd_tvalid,
  output logic                      s_axis_cmd_tready,
  output logic [CORE_CMD_WIDTH-1:0] m_axis_cmd_tdata,
  output logic                      m_axis_cmd_tvalid,
  input  logic                      m_axis_cmd_tready,
  input  logic [7:0]                s_axis_sts_tdata,
  input  logic                      s_axis_sts_tvalid,
  output logic                      s_axis_sts_tready,
  input  logic                      clear,
  output logic                      tile_done,
  output logic                      model_done,
  output logic                      err,
  output logic [3:0]                err_code,
  output logic [OUTSTD_W-1:0]       outstanding,
  output logic [15:0]               tile_cnt
);

  typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       gate_open;
  logic       cmd_hs, sts_hs;
  logic [3:0] sts_tag;
  logic [2:0] sts_flags;
  logic       sts_bad;
  logic [3:0] new_err;
  logic       tile_evt, model_evt;
  logic       tag_proto;

  assign sts_tag   = s_axis_sts_tdata[3:0];
  assign sts_flags = s_axis_sts_tdata[6:4];
  assign sts_bad   = ~s_axis_sts_tdata[7] | (|sts_flags);

  assign m_axis_cmd_tdata  = s_axis_cmd_tdata;
  assign m_axis_cmd_tvalid = s_axis_cmd_tvalid & gate_open;
  assign s_axis_cmd_tready = m_axis_cmd_tready & gate_open;
  assign cmd_hs            = m_axis_cmd_tvalid & m_axis_cmd_tready;

  // Status is drained even in ERR; only reset stops it.
  assign s_axis_sts_tready = rst_n;
  assign sts_hs            = s_axis_sts_tvalid & s_axis_sts_tready;

  assign err = |err_code;

`ifdef S2MM_STS_TAG_CHECK_EN
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  logic [3:0]     tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(MAX_OUTSTANDING));
  assign fifo_push  = cmd_hs & ~fifo_full;
  // A status with nothing to match is flagged, not popped.
  assign fifo_pop   = sts_hs & ~fifo_empty;
  assign tag_proto  = sts_hs & (fifo_empty | (tag_mem[rd_ptr] != sts_tag));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (fifo_pop && !fifo_push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) tag_mem[wr_ptr] <= s_axis_cmd_tdata[75:72];
  end
`else
  assign tag_proto = 1'b0;
`endif

  // Status decode: error bits, completion events and protocol checks.
  always_comb begin
    new_err   = 4'b0000;
    tile_evt  = 1'b0;
    model_evt = 1'b0;
    if (sts_hs) begin
      // OKAY=0 with no specific cause is reported as INTERR.
      if (sts_bad) new_err[2:0] = (sts_flags == 3'b000) ? 3'b001 : sts_flags;
      case (sts_tag)
        4'b1100: tile_evt = ~sts_bad;
        4'b1111: begin
          tile_evt  = ~sts_bad;
          model_evt = ~sts_bad;
        end
        4'b0000: ;
        default: new_err[3] = 1'b1;
      endcase
      if (outstanding == '0) new_err[3] = 1'b1;
      if (tag_proto)         new_err[3] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // A new error outranks clear in the same cycle.
  always_comb begin
    state_nxt = state;
    gate_open = 1'b0;
    if (new_err != 4'b0000) state_nxt = ERR;
    else if (clear)         state_nxt = RUN;
    if (state == RUN && outstanding < OUTSTD_W'(MAX_OUTSTANDING)) gate_open = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
      tile_done   <= 1'b0;
      model_done  <= 1'b0;
      err_code    <= 4'b0000;
      tile_cnt    <= 16'd0;
    end else begin
      if (cmd_hs && !sts_hs)                        outstanding <= outstanding + 1'b1;
      else if (sts_hs && !cmd_hs && outstanding != '0) outstanding <= outstanding - 1'b1;

      tile_done  <= tile_evt;
      err_code   <= (clear ? 4'b0000 : err_code) | new_err;
      model_done <= (clear ? 1'b0 : model_done) | model_evt;
      tile_cnt   <= (clear ? 16'd0 : tile_cnt) + {15'd0, tile_evt};
    end
  end

endmodule

// File: tb/tb_s2mm_sts_tracker.sv
module tb_s2mm_sts_tracker;

  logic        clk;
  logic        rst_n;
  logic [79:0] s_axis_cmd_tdata;
  logic        s_axis_cmd_tvalid;
  logic        s_axis_cmd_tready;
  logic [79:0] m_axis_cmd_tdata;
  logic        m_axis_cmd_tvalid;
  logic        m_axis_cmd_tready;
  logic [7:0]  s_axis_sts_tdata;
  logic        s_axis_sts_tvalid;
  logic        s_axis_sts_tready;
  logic        clear;
  logic        tile_done;
  logic        model_done;
  logic        err;
  logic [3:0]  err_code;
  logic [6:0]  outstanding;
  logic [15:0] tile_cnt;

  int n_chk = 0;
  int n_err = 0;

  s2mm_sts_tracker #(.CORE_CMD_WIDTH(80), .MAX_OUTSTANDING(16), .OUTSTD_W(7)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_cmd_tdata  (s_axis_cmd_tdata),
    .s_axis_cmd_tvalid (s_axis_cmd_tvalid),
    .s_axis_cmd_tready (s_axis_cmd_tready),
    .m_axis_cmd_tdata  (m_axis_cmd_tdata),
    .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
    .m_axis_cmd_tready (m_axis_cmd_tready),
    .s_axis_sts_tdata  (s_axis_sts_tdata),
    .s_axis_sts_tvalid (s_axis_sts_tvalid),
    .s_axis_sts_tready (s_axis_sts_tready),
    .clear             (clear),
    .tile_done         (tile_done),
    .model_done        (model_done),
    .err               (err),
    .err_code          (err_code),
    .outstanding       (outstanding),
    .tile_cnt          (tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk_cmd(input logic [3:0] tag);
    logic [79:0] c;
    c = 80'h0;
    c[75:72] = tag;
    c[15:0]  = 16'hA5A5;
    return c;
  endfunction

  task automatic send_cmd(input logic [3:0] tag);
    s_axis_cmd_tdata  = mk_cmd(tag);
    s_axis_cmd_tvalid = 1'b1;
    tick();
    s_axis_cmd_tvalid = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] d);
    s_axis_sts_tdata  = d;
    s_axis_sts_tvalid = 1'b1;
    tick();
    s_axis_sts_tvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    s_axis_cmd_tdata  = '0;
    s_axis_cmd_tvalid = 1'b0;
    m_axis_cmd_tready = 1'b0;
    s_axis_sts_tdata  = '0;
    s_axis_sts_tvalid = 1'b0;
    clear = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_sts_tready", s_axis_sts_tready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_flags", {tile_done, model_done, err}, 0);
    chk("rst_tile_cnt", tile_cnt, 0);
    rst_n = 1'b1;
    m_axis_cmd_tready = 1'b1;
    #1;
    chk("run_cmd_tready", s_axis_cmd_tready, 1);
    chk("run_sts_tready", s_axis_sts_tready, 1);

    // Fill to the outstanding limit: 15 intermediate + one tile command
    s_axis_cmd_tdata  = mk_cmd(4'b0000);
    s_axis_cmd_tvalid = 1'b1;
    #1;
    chk("pass_tvalid", m_axis_cmd_tvalid, 1);
    chk("pass_tdata", m_axis_cmd_tdata, 32'hA5A5);
    s_axis_cmd_tvalid = 1'b0;
    for (int i = 0; i < 16; i++) send_cmd(i < 15 ? 4'b0000 : 4'b1100);
    chk("full_outstanding", outstanding, 16);
    s_axis_cmd_tdata  = mk_cmd(4'b0000);
    s_axis_cmd_tvalid = 1'b1;
    #1;
    chk("full_cmd_tready", s_axis_cmd_tready, 0);
    chk("full_m_tvalid", m_axis_cmd_tvalid, 0);
    s_axis_cmd_tvalid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_sts(i < 15 ? 8'h80 : 8'h8C);
      if (i == 0) begin
        chk("reopen_outstanding", outstanding, 15);
        chk("reopen_cmd_tready", s_axis_cmd_tready, 1);
      end
      if (i == 14) chk("no_early_tile_done", tile_done, 0);
    end
    chk("tile_done_pulse", tile_done, 1);
    chk("tile_cnt_1", tile_cnt, 1);
    chk("drain_outstanding", outstanding, 0);
    tick();
    chk("tile_done_one_cycle", tile_done, 0);

    // End of model
    send_cmd(4'b1111);
    send_sts(8'h8F);
    chk("model_tile_done", tile_done, 1);
    chk("model_done", model_done, 1);
    chk("model_tile_cnt", tile_cnt, 2);
    pulse_clear();
    chk("clr_model_done", model_done, 0);
    chk("clr_tile_cnt", tile_cnt, 0);

    // SLVERR blocks further commands until clear
    send_cmd(4'b1100);
    send_sts(8'h4C);
    chk("slverr_err", err, 1);
    chk("slverr_code", err_code, 4'b0100);
    chk("slverr_no_tile", tile_done, 0);
    chk("slverr_outstanding", outstanding, 0);
    s_axis_cmd_tdata  = mk_cmd(4'b0000);
    s_axis_cmd_tvalid = 1'b1;
    #1;
    chk("err_stall_tvalid", m_axis_cmd_tvalid, 0);
    chk("err_stall_tready", s_axis_cmd_tready, 0);
    pulse_clear();
    chk("clr_fwd_tvalid", m_axis_cmd_tvalid, 1);
    chk("clr_err", err, 0);
    tick();
    s_axis_cmd_tvalid = 1'b0;
    chk("clr_fwd_outstanding", outstanding, 1);
    send_sts(8'h80);
    chk("clr_drain", outstanding, 0);

    // Status underflow
    send_sts(8'h80);
    chk("uflow_code", err_code, 4'b1000);
    chk("uflow_outstanding", outstanding, 0);
    pulse_clear();
    chk("uflow_clear", err_code, 0);

    // Illegal tag
    send_cmd(4'b0000);
    send_sts(8'h85);
    chk("bad_tag_code", err_code, 4'b1000);
    pulse_clear();

    // Simultaneous cmd and status handshakes
    for (int i = 0; i < 5; i++) send_cmd(4'b0000);
    chk("five_outstanding", outstanding, 5);
    s_axis_cmd_tdata  = mk_cmd(4'b0000);
    s_axis_cmd_tvalid = 1'b1;
    send_sts(8'h80);
    s_axis_cmd_tvalid = 1'b0;
    chk("both_hs_outstanding", outstanding, 5);
    chk("both_hs_no_err", err_code, 0);
    for (int i = 0; i < 5; i++) send_sts(8'h80);
    chk("both_hs_drain", outstanding, 0);

    // Tag mismatch: tile command answered by end-of-model status
    send_cmd(4'b1100);
    send_sts(8'h8F);
`ifdef S2MM_STS_TAG_CHECK_EN
    chk("tag_mismatch_proto", err_code, 4'b1000);
`else
    chk("tag_nocheck_code", err_code, 4'b0000);
    chk("tag_nocheck_model", model_done, 1);
`endif
    pulse_clear();

    // Reset in the middle of operation
    for (int i = 0; i < 4; i++) send_cmd(4'b0000);
    send_sts(8'h40);
    chk("pre_rst_outstanding", outstanding, 3);
    chk("pre_rst_err", err, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sts_tready", s_axis_sts_tready, 0);
    tick();
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_flags", {tile_done, model_done, err}, 0);
    chk("mid_rst_tile_cnt", tile_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_tready", s_axis_cmd_tready, 1);
    acc = 0;
    s_axis_cmd_tdata  = mk_cmd(4'b0000);
    s_axis_cmd_tvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_axis_cmd_tready) acc++;
      tick();
    end
    s_axis_cmd_tvalid = 1'b0;
    chk("post_rst_accepted", acc, 16);
    chk("post_rst_backpressure", s_axis_cmd_tready, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/s2mm_sts_tracker.md
# s2mm_sts_tracker

Sits between `s2mm_cmd_gen` and the AXI DataMover S2MM engine. It forwards data mover commands and gates them against an outstanding-command limit. It also consumes the DataMover S2MM status stream, matches each status to its command, and raises the per-tile and end-of-model completion flags the controller uses for synchronisation. DataMover errors and protocol violations are latched as sticky flags, and further commands are blocked until software clears them.

## Interface
- `CORE_CMD_WIDTH`, 80: command width; tag at bits [75:72].
- `MAX_OUTSTANDING`, 16: maximum commands issued but not yet acknowledged by status; power of two, range 2..64.
- `OUTSTD_W`, 7: width of `outstanding`; must satisfy 2^OUTSTD_W > MAX_OUTSTANDING.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_axis_cmd_tdata` in CORE_CMD_WIDTH: command from `s2mm_cmd_gen`.
- `s_axis_cmd_tvalid` in 1 / `s_axis_cmd_tready` out 1: command handshake from `s2mm_cmd_gen`.
- `m_axis_cmd_tdata` out CORE_CMD_WIDTH: command to the DataMover; equals `s_axis_cmd_tdata`, combinational.
- `m_axis_cmd_tvalid` out 1 / `m_axis_cmd_tready` in 1: command handshake to the DataMover.
- `s_axis_sts_tdata` in 8: DataMover status; [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY.
- `s_axis_sts_tvalid` in 1 / `s_axis_sts_tready` out 1: status handshake.
- `clear` in 1: synchronous clear of sticky flags, `tile_cnt`, and the error state.
- `tile_done` out 1: one-cycle pulse per completed tile.
- `model_done` out 1: sticky end-of-model flag.
- `err` out 1: sticky error flag.
- `err_code` out 4: sticky OR of {PROTO, SLVERR, DECERR, INTERR}, MSB first.
- `outstanding` out OUTSTD_W: commands in flight.
- `tile_cnt` out 16: number of completed tiles; wraps at 65535 → 0.

## Operation
- The state machine has two states.
  - RUN (reset state): commands pass through.
  - ERR: entered the cycle after any error is latched; the command gate is closed; exit to RUN on `clear`.
- Command gate:
  - `gate_open = (state == RUN) & (outstanding < MAX_OUTSTANDING)`.
  - `m_axis_cmd_tvalid = s_axis_cmd_tvalid & gate_open`.
  - `s_axis_cmd_tready = m_axis_cmd_tready & gate_open`.
  - A command handshake (cmd_hs) is `m_axis_cmd_tvalid & m_axis_cmd_tready`.
- `s_axis_sts_tready` is 1 whenever `rst_n` is 1. A status handshake (sts_hs) is `s_axis_sts_tvalid & s_axis_sts_tready`.
- Outstanding counter:
  - +1 on cmd_hs only; −1 on sts_hs only; unchanged when both occur in the same cycle.
  - An sts_hs while `outstanding == 0` sets PROTO and leaves the counter at 0.
- Status decode, on each sts_hs:
  - If OKAY=0, or any of [6:4] is set: OR [6:4] into `err_code[2:0]`. OKAY=0 with [6:4]=0 sets INTERR.
  - Tag 4'b1100 or 4'b1111 with no error: `tile_done` pulses and `tile_cnt` increments.
  - Tag 4'b1111 with no error: `model_done` is also set.
  - Tag 4'b0000 (intermediate row or channel command): no completion action.
  - Any other tag value sets PROTO.
- `err = |err_code`.
- Errored statuses still decrement `outstanding`. Statuses are still accepted in ERR so the DataMover can drain.
- `clear` zeroes `err_code`, `model_done`, and `tile_cnt`, and moves ERR → RUN. `outstanding` and the tag FIFO are not affected.
- If `clear` and a new error occur in the same cycle, the new error wins: the flag is set and the state stays or becomes ERR.
- Reset values:
  - `tile_done`, `model_done`, `err`, `err_code`, `outstanding`, `tile_cnt` = 0.
  - State = RUN, so `s_axis_cmd_tready` follows `m_axis_cmd_tready`.
  - During reset `s_axis_sts_tready` = 0.
  - A reset in the middle of operation discards all in-flight tracking.

## Timing
- Command path: combinational, zero latency, no registers.
- `tile_done` and `model_done` rise in cycle N+1 after an sts_hs in cycle N.
- `outstanding` and `tile_cnt` update in cycle N+1.
- Errors: `err` and `err_code` update in cycle N+1. The state becomes ERR in cycle N+1, so the gate is closed from cycle N+1.
- Full boundary: when `outstanding == MAX_OUTSTANDING`, `s_axis_cmd_tready` = 0. An sts_hs in cycle N reopens the gate in cycle N+1.
- Status accept rate: one status per cycle sustained. Back-to-back `tile_done` pulses are permitted.

## Configuration
- `S2MM_STS_TAG_CHECK_EN`, when defined:
  - Each cmd_hs pushes cmd tag [75:72] into a MAX_OUTSTANDING-deep FIFO.
  - Each sts_hs pops the FIFO and compares the popped tag with the status tag; a mismatch sets PROTO.
  - An sts_hs on an empty FIFO sets PROTO and does not pop.
- When undefined: no FIFO and no comparison; only the counter underflow and illegal-tag checks set PROTO.

## Test plan
- Sixteen commands with tags 0000×15 then 1100, `m_axis_cmd_tready`=1 → `outstanding` reaches 16 and `s_axis_cmd_tready` drops. Sixteen OKAY statuses (0x80, …, 0x8C) → a single `tile_done` pulse after the last one; `tile_cnt`=1; `outstanding`=0.
- One command with tag 1111, then status 0x8F → `tile_done` and `model_done` = 1 one cycle after the status. Pulse `clear` → `model_done`=0, `tile_cnt`=0.
- Status 0x4C (SLVERR) → `err`=1, `err_code`=4'b0100. The next command is stalled (`m_axis_cmd_tvalid`=0). `clear` → command forwarded the following cycle.
- Status with `outstanding`=0 → `err_code`=4'b1000 and `outstanding` stays 0.
- cmd_hs and sts_hs in the same cycle with `outstanding`=5 → stays 5. With `S2MM_STS_TAG_CHECK_EN`: command tag 1100 answered by status tag 1111 → PROTO set.
- Assert `rst_n`=0 with 3 outstanding → all outputs 0 and state RUN. After reset, 16 new commands are accepted before backpressure.
